// File: rtl/dst_stream_pkg.sv
// Shared types and constants for the dst_buf drain path.
package dst_stream_pkg;

    localparam int DST_BANK_BIT = 12;
    localparam int DST_IDX_W    = 11;
    localparam int DST_ADDR_W   = 13;

    // One output beat as held in the FIFO.
    typedef struct packed {
        logic        last;
        logic [31:0] d1;
        logic [31:0] d0;
    } dst_beat_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } dst_state_t;

    // dst_buf address: bank-pair select on top, bit 11 always zero.
    function automatic logic [DST_ADDR_W-1:0] dst_addr(input logic bank,
                                                       input logic [DST_IDX_W-1:0] idx);
        return {bank, 1'b0, idx};
    endfunction

endpackage

// File: rtl/dst_stream_if.sv
// dst_buf read port plus the 64-bit output stream of the drain engine.
interface dst_stream_if import dst_stream_pkg::*; ();

    logic                  dst_v;
    logic [DST_ADDR_W-1:0] dst_a;
    logic [31:0]           dst_d0;
    logic [31:0]           dst_d1;
    logic                  m_valid;
    logic                  m_ready;
    logic [63:0]           m_data;
    logic                  m_last;

    modport master (
        output dst_v, dst_a, m_valid, m_data, m_last,
        input  dst_d0, dst_d1, m_ready
    );

    modport slave (
        input  dst_v, dst_a, m_valid, m_data, m_last,
        output dst_d0, dst_d1, m_ready
    );

endinterface

// File: rtl/dst_stream_fifo2.sv
// Two-entry valid/ready FIFO with occupancy output; push and pop may coincide.
module dst_stream_fifo2 #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_pop;

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign w_pop   = o_valid & i_ready;

    // Storage, pointers and occupancy; the producer guarantees no push when full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dst_stream.sv
// Drains dst_buf entries onto a 64-bit valid/ready stream.
//
//  state | meaning
//  IDLE  | waiting for start
//  RUN   | issuing reads while credit allows and acc_busy is low
//  DRAIN | all reads issued; waiting for the last beat to be accepted
//  DONE  | one-cycle done pulse
module dst_stream import dst_stream_pkg::*; #(
    parameter int IDX_W = DST_IDX_W,
    parameter int LEN_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W+1:0] base,
    input  logic [LEN_W-1:0] len,
    input  logic             acc_busy,
    output logic             busy,
    output logic             done,
    dst_stream_if.master     bus
);

    dst_state_t       r_state;
    dst_state_t       w_next;
    logic             r_bank;
    logic [IDX_W-1:0] r_idx;
    logic [LEN_W-1:0] r_rem;
    logic             r_rd_pend;
    logic             r_rd_last;

    logic             w_issue;
    logic             w_last_issue;
    logic             w_pop;
    logic [2:0]       w_occ;
    logic [1:0]       w_count;
    logic             w_fifo_valid;
    dst_beat_t        w_push_beat;
    dst_beat_t        w_head;
    logic             w_unused_base;

    // Bit 11 of the start address carries no meaning for dst_buf.
    assign w_unused_base = base[IDX_W];

    // Occupancy the FIFO would have if every in-flight read landed now.
    assign w_occ        = {1'b0, w_count} + {2'b0, r_rd_pend} - {2'b0, w_pop};
    assign w_issue      = (r_state == RUN) && !acc_busy && (w_occ < 3'd2);
    assign w_last_issue = w_issue && (r_rem == LEN_W'(1));
    assign w_pop        = w_fifo_valid & bus.m_ready;

    // Address is registered so it only moves on an issue and never flips bank mid-transfer.
    assign bus.dst_v = w_issue;
    assign bus.dst_a = dst_addr(r_bank, r_idx);

    assign w_push_beat = '{last: r_rd_last, d1: bus.dst_d1, d0: bus.dst_d0};

    dst_stream_fifo2 #(
        .W($bits(dst_beat_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_rd_pend),
        .i_data  (w_push_beat),
        .i_ready (bus.m_ready),
        .o_valid (w_fifo_valid),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign bus.m_valid = w_fifo_valid;
    assign bus.m_data  = {w_head.d1, w_head.d0};
    assign bus.m_last  = w_fifo_valid & w_head.last;

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

    // State, read address/length tracking and the one-cycle read-latency pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bank    <= 1'b0;
            r_idx     <= '0;
            r_rem     <= '0;
            r_rd_pend <= 1'b0;
            r_rd_last <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_rd_pend <= w_issue;
            r_rd_last <= w_last_issue;
            if (r_state == IDLE && start && len != '0) begin
                r_bank <= base[DST_BANK_BIT];
                r_idx  <= base[IDX_W-1:0];
                r_rem  <= len;
            end else if (w_issue) begin
                r_rem <= r_rem - 1'b1;
                if (!w_last_issue) begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    // Next-state logic; the final handshake moves DRAIN to DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (len != '0) ? RUN : DONE;
            RUN:     if (w_last_issue) w_next = DRAIN;
            DRAIN:   if (w_pop && w_head.last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dst_stream.sv
// Directed bench for dst_stream with a registered dst_buf model.
module tb_dst_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [12:0] base;
    logic [11:0] len;
    logic        acc_busy;
    logic        busy;
    logic        done;

    int n_chk = 0;
    int n_err = 0;

    dst_stream_if bus ();

    dst_stream #(.IDX_W(11), .LEN_W(12)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base     (base),
        .len      (len),
        .acc_busy (acc_busy),
        .busy     (busy),
        .done     (done),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // dst_buf model: entry at address a reads back {0x100+a, 0x200+a}, one cycle after dst_v.
    always @(posedge clk) begin
        if (bus.dst_v) begin
            bus.dst_d1 <= 32'h100 + {19'd0, bus.dst_a};
            bus.dst_d0 <= 32'h200 + {19'd0, bus.dst_a};
        end
    end

    function automatic logic [12:0] exp_addr(input logic [12:0] b, input int k);
        logic [10:0] i;
        i = b[10:0] + 11'(k);
        return {b[12], 1'b0, i};
    endfunction

    function automatic logic [63:0] exp_data(input logic [12:0] a);
        return {32'h100 + {19'd0, a}, 32'h200 + {19'd0, a}};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Unobstructed transfer (m_ready=1, acc_busy=0): start in cycle 0, reads in
    // cycles 1..len, beats in cycles 3..len+2, done in cycle len+3.
    task automatic run_free(input logic [12:0] b, input int n);
        tick();
        start = 1'b1; base = b; len = 12'(n); bus.m_ready = 1'b1; acc_busy = 1'b0;
        for (int c = 1; c <= n + 4; c++) begin
            tick();
            start = 1'b0;
            #1;
            chk("free_dst_v", bus.dst_v, (c >= 1 && c <= n));
            if (c >= 1 && c <= n) chk("free_dst_a", bus.dst_a, exp_addr(b, c - 1));
            if (c <= n + 3) chk("free_bank", bus.dst_a[12], b[12]);
            chk("free_m_valid", bus.m_valid, (c >= 3 && c <= n + 2));
            if (c >= 3 && c <= n + 2) begin
                chk("free_m_data", bus.m_data, exp_data(exp_addr(b, c - 3)));
                chk("free_m_last", bus.m_last, (c == n + 2));
            end
            chk("free_done", done, (c == n + 3));
            chk("free_busy", busy, (c <= n + 3));
        end
    endtask

    initial begin
        int          n_iss;
        int          n_acc;
        int          last_hs;
        bit          seen_done;
        bit          stalled;
        logic [63:0] held;
        logic        pop;

        rst_n = 1'b0; start = 1'b0; base = '0; len = '0; acc_busy = 1'b0;
        bus.m_ready = 1'b0; bus.dst_d0 = '0; bus.dst_d1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dst_v", bus.dst_v, 0);
        chk("rst_dst_a", bus.dst_a, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_last", bus.m_last, 0);
        rst_n = 1'b1;

        // Basic drain of entries 0..3, then bank 1 with index wrap 0x7FF -> 0.
        run_free(13'h0000, 4);
        run_free(13'h17FE, 3);

        // Zero length: straight to DONE, no beats.
        tick();
        start = 1'b1; base = 13'h1234; len = 12'd0;
        tick();
        start = 1'b0;
        #1;
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 1);
        chk("len0_dst_v", bus.dst_v, 0);
        chk("len0_m_valid", bus.m_valid, 0);
        tick();
        chk("len0_done_clear", done, 0);
        chk("len0_idle", busy, 0);

        // Backpressure with m_ready pattern 1,0,0,1 and a start pulse while busy.
        tick();
        start = 1'b1; base = 13'h0040; len = 12'd8; bus.m_ready = 1'b1;
        n_iss = 0; n_acc = 0; seen_done = 0; stalled = 0; held = '0; last_hs = -10;
        for (int c = 1; c <= 80; c++) begin
            tick();
            start       = (c == 5);
            base        = (c == 5) ? 13'h0100 : 13'h0040;
            len         = (c == 5) ? 12'd3 : 12'd8;
            bus.m_ready = (c % 4 == 0) || (c % 4 == 3);
            #1;
            pop = bus.m_valid & bus.m_ready;
            if (bus.dst_v) begin
                chk("bp_dst_a", bus.dst_a, exp_addr(13'h0040, n_iss));
                chk("bp_credit", ((n_iss - n_acc - int'(pop)) < 2), 1);
                n_iss++;
            end
            if (bus.m_valid) begin
                if (stalled) chk("bp_hold", bus.m_data, held);
                chk("bp_m_data", bus.m_data, exp_data(exp_addr(13'h0040, n_acc)));
                chk("bp_m_last", bus.m_last, (n_acc == 7));
                held    = bus.m_data;
                stalled = !bus.m_ready;
                if (bus.m_ready) begin
                    n_acc++;
                    last_hs = c;
                end
            end else begin
                stalled = 0;
            end
            if (done) begin
                seen_done = 1;
                chk("bp_done_timing", c, last_hs + 1);
                break;
            end
        end
        start = 1'b0;
        chk("bp_seen_done", seen_done, 1);
        chk("bp_beats", n_acc, 8);
        chk("bp_reads", n_iss, 8);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_ignored_start_v", bus.dst_v, 0);
            chk("bp_ignored_start_busy", busy, 0);
        end

        // acc_busy held for 5 cycles mid-transfer.
        tick();
        start = 1'b1; base = 13'h0010; len = 12'd6; bus.m_ready = 1'b1;
        n_iss = 0; n_acc = 0; seen_done = 0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            start    = 1'b0;
            acc_busy = (c >= 3 && c <= 7);
            #1;
            if (acc_busy) chk("ab_no_dst_v", bus.dst_v, 0);
            if (bus.dst_v) begin
                chk("ab_dst_a", bus.dst_a, exp_addr(13'h0010, n_iss));
                n_iss++;
            end
            if (bus.m_valid) begin
                chk("ab_m_data", bus.m_data, exp_data(exp_addr(13'h0010, n_acc)));
                chk("ab_m_last", bus.m_last, (n_acc == 5));
                n_acc++;
            end
            if (done) begin
                seen_done = 1;
                break;
            end
        end
        acc_busy = 1'b0;
        chk("ab_seen_done", seen_done, 1);
        chk("ab_beats", n_acc, 6);
        chk("ab_reads", n_iss, 6);

        // Async reset in the middle of RUN.
        tick();
        start = 1'b1; base = 13'h1005; len = 12'd8; bus.m_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_dst_v", bus.dst_v, 0);
        chk("arst_dst_a", bus.dst_a, 0);
        chk("arst_m_valid", bus.m_valid, 0);
        chk("arst_m_last", bus.m_last, 0);
        tick();
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("arst_no_done", done, 0);
            chk("arst_no_valid", bus.m_valid, 0);
        end
        run_free(13'h0020, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
